bcd_seg_counter: RTL and testbench

- Downstream consumer of the debounced push-switch level produced by the switch chattering-inhibit stage.
- Counts switch presses as a multi-digit decimal (BCD) up/down counter and drives the board's active-low 7-segment displays.
- Replaces the single-digit LED count with a synchronised, edge-detected, cascaded-carry counter and registered segment outputs.

---
 rtl/bcd_seg_pkg.sv | 16 +
 rtl/bcd_seg_counter_seg7_dec.sv | 19 +
 rtl/bcd_seg_counter.sv | 150 +++++++++++++++
 tb/tb_bcd_seg_counter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// bcd_seg_pkg: shared widths and glyph table for the BCD counter.
// Optional build macro BCD_SEG_LZB_EN affects seg blanking only.
package bcd_seg_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // active-low g..a glyphs, entry n is digit n
  localparam logic [9:0][SEG_W-1:0] SEG_GLYPH = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_seg_counter_seg7_dec.sv
// seg7_dec: one BCD digit to an active-low g..a pattern.
// Combinational only; the caller registers the result.
module seg7_dec
  import bcd_seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_o
);

  // glyph lookup, blanked on request or for non-BCD codes
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (bcd_i <= 4'd9)) begin
      seg_o = SEG_GLYPH[bcd_i];
    end
  end

endmodule

// File: rtl/bcd_seg_counter.sv
// bcd_seg_counter: press counter, cascaded BCD digits, 7-seg drive.
// Define BCD_SEG_LZB_EN to blank leading zero digits on seg.
module bcd_seg_counter
  import bcd_seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sw_in,
  input  logic                      dn,
  input  logic                      clr,
  output logic [DIGITS*BCD_W-1:0]   bcd,
  output logic [DIGITS*SEG_W-1:0]   seg,
  output logic                      wrap
);

  logic [SYNC_STAGES-1:0]         sync_q;
  logic [SYNC_STAGES-1:0]         sync_d;
  logic                           edge_q;
  logic                           live_q;
  logic                           armed_q;
  logic                           armed_d;
  logic                           inc;

  logic [DIGITS-1:0][BCD_W-1:0]   dig_q;
  logic [DIGITS-1:0][BCD_W-1:0]   dig_d;
  logic                           wrap_q;
  logic                           wrap_d;
  logic                           cy;

  logic [DIGITS-1:0]              blank;
  logic [DIGITS-1:0][SEG_W-1:0]   dec_w;
  logic [DIGITS-1:0][SEG_W-1:0]   seg_q;

  // armed only after a real low sample, so a level high at reset
  // release is never taken as an edge
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sw_in};
    armed_d = armed_q | (live_q & ~sync_q[0]);
    inc     = sync_q[SYNC_STAGES-1] & ~edge_q & armed_q;
  end

  // synchroniser, edge register and arming flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      live_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= sync_q[SYNC_STAGES-1];
      live_q  <= 1'b1;
      armed_q <= armed_d;
    end
  end

  // ripple carry/borrow across digits; clear beats a count
  always_comb begin
    dig_d  = dig_q;
    wrap_d = wrap_q;
    cy     = 1'b1;
    if (clr) begin
      dig_d  = '0;
      wrap_d = 1'b0;
    end else if (inc) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (cy) begin
          if (!dn) begin
            if (dig_q[k] == 4'd9) begin
              dig_d[k] = 4'd0;
            end else begin
              dig_d[k] = dig_q[k] + 4'd1;
              cy       = 1'b0;
            end
          end else begin
            if (dig_q[k] == 4'd0) begin
              dig_d[k] = 4'd9;
            end else begin
              dig_d[k] = dig_q[k] - 4'd1;
              cy       = 1'b0;
            end
          end
        end
      end
      if (cy) begin
        wrap_d = 1'b1;
      end
    end
  end

  // count and sticky wrap registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      dig_q  <= dig_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef BCD_SEG_LZB_EN
  // blank digit k>0 while it and every higher digit are zero
  always_comb begin
    logic hz;
    blank = '0;
    hz    = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hz       = hz & (dig_q[k] == 4'd0);
      blank[k] = hz;
    end
  end
`else
  // every digit always shows its glyph
  always_comb begin
    blank = '0;
  end
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_dec u_dec (
      .bcd_i   (dig_q[g]),
      .blank_i (blank[g]),
      .seg_o   (dec_w[g])
    );
  end

  // registered segment drive; reset shows a zero count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIGITS; k++) begin
`ifdef BCD_SEG_LZB_EN
        seg_q[k] <= (k == 0) ? SEG_GLYPH[0] : SEG_BLANK;
`else
        seg_q[k] <= SEG_GLYPH[0];
`endif
      end
    end else begin
      seg_q <= dec_w;
    end
  end

  assign bcd  = dig_q;
  assign seg  = seg_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_seg_counter.sv
// tb_bcd_seg_counter: directed checks of count, carry, wrap, clear,
// reset and segment drive for the default 4-digit build.
module tb_bcd_seg_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_in;
  logic        dn;
  logic        clr;
  logic [15:0] bcd;
  logic [27:0] seg;
  logic        wrap;

  int passed = 0;
  int total  = 0;

  localparam logic [27:0] SEG_9999 = {7'h10, 7'h10, 7'h10, 7'h10};
`ifdef BCD_SEG_LZB_EN
  localparam logic [27:0] SEG_0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] SEG_0001 = {7'h7F, 7'h7F, 7'h7F, 7'h79};
  localparam logic [27:0] SEG_0099 = {7'h7F, 7'h7F, 7'h10, 7'h10};
  localparam logic [27:0] SEG_0100 = {7'h7F, 7'h79, 7'h40, 7'h40};
`else
  localparam logic [27:0] SEG_0000 = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] SEG_0001 = {7'h40, 7'h40, 7'h40, 7'h79};
  localparam logic [27:0] SEG_0099 = {7'h40, 7'h40, 7'h10, 7'h10};
  localparam logic [27:0] SEG_0100 = {7'h40, 7'h79, 7'h40, 7'h40};
`endif

  bcd_seg_counter #(.DIGITS(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_in (sw_in),
    .dn    (dn),
    .clr   (clr),
    .bcd   (bcd),
    .seg   (seg),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic press();
    sw_in = 1'b1;
    tick(3);
    sw_in = 1'b0;
    tick(3);
  endtask

  task automatic fast_press(input int n);
    for (int i = 0; i < n; i++) begin
      sw_in = 1'b1;
      tick();
      sw_in = 1'b0;
      tick();
    end
    tick(4);
  endtask

  initial begin
    rst_n = 1'b0;
    sw_in = 1'b0;
    dn    = 1'b0;
    clr   = 1'b0;
    #23;
    chk("rst_bcd", 32'(bcd), 32'h0000);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_seg", 32'(seg), 32'(SEG_0000));
    rst_n = 1'b1;
    tick(3);
    chk("rel_bcd", 32'(bcd), 32'h0000);
    chk("rel_seg", 32'(seg), 32'(SEG_0000));

    sw_in = 1'b1;
    tick();
    chk("lat_e0", 32'(bcd), 32'h0000);
    tick();
    chk("lat_e1", 32'(bcd), 32'h0000);
    tick();
    chk("lat_e2_bcd", 32'(bcd), 32'h0001);
    chk("lat_e2_seg", 32'(seg), 32'(SEG_0000));
    tick();
    chk("lat_e3_seg", 32'(seg), 32'(SEG_0001));
    tick(6);
    chk("held_bcd", 32'(bcd), 32'h0001);
    sw_in = 1'b0;
    tick(4);
    chk("fall_bcd", 32'(bcd), 32'h0001);

    dn = 1'b1;
    press();
    chk("down_1_0", 32'(bcd), 32'h0000);
    chk("down_wrap", 32'(wrap), 32'h0);
    dn = 1'b0;

    fast_press(99);
    chk("pre_99", 32'(bcd), 32'h0099);
    chk("seg_99", 32'(seg), 32'(SEG_0099));
    press();
    chk("carry_100", 32'(bcd), 32'h0100);
    chk("seg_100", 32'(seg), 32'(SEG_0100));

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_bcd", 32'(bcd), 32'h0000);

    fast_press(9999);
    chk("pre_9999", 32'(bcd), 32'h9999);
    chk("wrap_pre", 32'(wrap), 32'h0);
    chk("seg_9999", 32'(seg), 32'(SEG_9999));
    press();
    chk("up_wrap_bcd", 32'(bcd), 32'h0000);
    chk("up_wrap_flag", 32'(wrap), 32'h1);
    dn = 1'b1;
    press();
    chk("dn_wrap_bcd", 32'(bcd), 32'h9999);
    chk("dn_wrap_flag", 32'(wrap), 32'h1);
    dn = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr2_bcd", 32'(bcd), 32'h0000);
    chk("clr2_wrap", 32'(wrap), 32'h0);

    sw_in = 1'b1;
    tick(2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(3);
    chk("clr_vs_inc", 32'(bcd), 32'h0000);
    sw_in = 1'b0;
    tick(3);

    press();
    chk("pre_rst", 32'(bcd), 32'h0001);
    sw_in = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bcd", 32'(bcd), 32'h0000);
    chk("mid_rst_seg", 32'(seg), 32'(SEG_0000));
    #2;
    rst_n = 1'b1;
    tick(8);
    chk("hi_rel_bcd", 32'(bcd), 32'h0000);
    sw_in = 1'b0;
    tick(3);
    press();
    chk("fresh_edge", 32'(bcd), 32'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
